// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared ECC datapath definitions: default operand width and
//               the IDLE/RUN/DONE state encoding used by the sequencers.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

  localparam int N_DEFAULT = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/modular_inversion_if.sv
`default_nettype none
// ============================================================================
// Module      : modular_inversion_if
// Description : Request/result bundle of the modular inverter. The master
//               side supplies modulus, operand and start; the slave side
//               returns busy, the inverse and the completion flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface modular_inversion_if
  import ecc_pkg::*;
#(
  parameter int N = N_DEFAULT
) ();

  logic [N-1:0] p;
  logic [N-1:0] a;
  logic         start;
  logic         busy;
  logic [N-1:0] result;
  logic         result_ready;
  logic         no_inverse;

  modport master (
    output p, a, start,
    input  busy, result, result_ready, no_inverse
  );

  modport slave (
    input  p, a, start,
    output busy, result, result_ready, no_inverse
  );

endinterface
`default_nettype wire

// File: rtl/mod_half.sv
`default_nettype none
// ============================================================================
// Module      : mod_half
// Description : Modular halving x/2 mod p for odd p and x < p. An odd x has
//               p added first so the sum is even; the sum needs one extra bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_half #(
  parameter int N = 10
) (
  input  wire [N-1:0] x,
  input  wire [N-1:0] p,
  output logic [N-1:0] h
);

  logic [N:0] sum;

  // Make the value even (adding p keeps the residue), then shift
  always_comb begin
    sum = {1'b0, x} + (x[0] ? {1'b0, p} : {(N+1){1'b0}});
    h   = N'(sum >> 1);
  end

endmodule
`default_nettype wire

// File: rtl/modular_inversion.sv
`default_nettype none
// ============================================================================
// Module      : modular_inversion
// Description : Binary extended Euclid inverter, a^-1 mod p, one reduction
//               step per clock. Invariants x1*a = u and x2*a = v (mod p)
//               hold throughout, so u == 1 or v == 1 yields the inverse.
// Revision    : 1.0 - initial release
// ============================================================================
module modular_inversion
  import ecc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input wire                 clk,
  input wire                 reset,
  modular_inversion_if.slave bus
);

  state_t       state_q, state_d;
  logic [N-1:0] u_q, u_d;
  logic [N-1:0] v_q, v_d;
  logic [N-1:0] x1_q, x1_d;
  logic [N-1:0] x2_q, x2_d;
  logic [N-1:0] pr_q, pr_d;
  logic [N-1:0] result_q, result_d;
  logic         ready_q, ready_d;
  logic         no_inv_q, no_inv_d;

  logic [N-1:0] x1_half;
  logic [N-1:0] x2_half;

  logic         u_ge_v;
  logic [N-1:0] sub_big, sub_small, sub_diff;
  logic [N-1:0] xa, xb, x_mod;
  logic [N:0]   xd;

  mod_half #(.N(N)) u_half_x1 (.x(x1_q), .p(pr_q), .h(x1_half));
  mod_half #(.N(N)) u_half_x2 (.x(x2_q), .p(pr_q), .h(x2_half));

  // One shared subtractor: operands swapped so the larger of u/v is reduced
  always_comb begin
    u_ge_v    = (u_q >= v_q);
    sub_big   = u_ge_v ? u_q  : v_q;
    sub_small = u_ge_v ? v_q  : u_q;
    xa        = u_ge_v ? x1_q : x2_q;
    xb        = u_ge_v ? x2_q : x1_q;
    sub_diff  = sub_big - sub_small;
    xd        = {1'b0, xa} - {1'b0, xb};
    // A borrow means xa < xb; adding pr wraps back into [0, pr-1]
    x_mod     = xd[N] ? (xd[N-1:0] + pr_q) : xd[N-1:0];
  end

  // Next-state and datapath update, one reduction per RUN cycle
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    pr_d     = pr_q;
    result_d = result_q;
    ready_d  = ready_q;
    no_inv_d = no_inv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          u_d      = bus.a;
          v_d      = bus.p;
          x1_d     = N'(1);
          x2_d     = '0;
          pr_d     = bus.p;
          result_d = '0;
          ready_d  = 1'b0;
          no_inv_d = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (u_q == '0) begin
          no_inv_d = 1'b1;
          state_d  = S_DONE;
        end else if (u_q == N'(1)) begin
          result_d = x1_q;
          ready_d  = 1'b1;
          state_d  = S_DONE;
        end else if (v_q == N'(1)) begin
          result_d = x2_q;
          ready_d  = 1'b1;
          state_d  = S_DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_ge_v) begin
          u_d  = sub_diff;
          x1_d = x_mod;
        end else begin
          v_d  = sub_diff;
          x2_d = x_mod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      pr_q     <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      no_inv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      pr_q     <= pr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      no_inv_q <= no_inv_d;
    end
  end

  assign bus.busy         = (state_q == S_RUN);
  assign bus.result       = result_q;
  assign bus.result_ready = ready_q;
  assign bus.no_inverse   = no_inv_q;

endmodule
`default_nettype wire

// File: tb/tb_modular_inversion.sv
`default_nettype none
// ============================================================================
// Module      : tb_modular_inversion
// Description : Directed self-checking bench for modular_inversion.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modular_inversion;
  import ecc_pkg::*;

  localparam int N = N_DEFAULT;

  logic clk = 1'b0;
  logic reset = 1'b0;

  modular_inversion_if #(.N(N)) bus ();

  modular_inversion #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise start for exactly one rising edge; returns one cycle after it.
  task automatic launch(input logic [N-1:0] pv, input logic [N-1:0] av);
    @(negedge clk);
    bus.p     = pv;
    bus.a     = av;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycles counted from the cycle start was raised; bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!(bus.result_ready || bus.no_inverse) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] pv, input logic [N-1:0] av,
                        input logic [N-1:0] exp_res, output int cyc);
    launch(pv, av);
    chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    chk({tag, " ready_dropped"}, 32'(bus.result_ready), 32'd0);
    wait_done(cyc);
    chk({tag, " result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, " ready"}, 32'(bus.result_ready), 32'd1);
    chk({tag, " no_inverse"}, 32'(bus.no_inverse), 32'd0);
    chk({tag, " busy_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " latency_ok"}, 32'(cyc <= 4 * N + 2), 32'd1);
  endtask

  logic [N-1:0] exp17 [1:16];

  initial begin
    int cyc;
    exp17[1]  = 10'd1;  exp17[2]  = 10'd9;  exp17[3]  = 10'd6;  exp17[4]  = 10'd13;
    exp17[5]  = 10'd7;  exp17[6]  = 10'd3;  exp17[7]  = 10'd5;  exp17[8]  = 10'd15;
    exp17[9]  = 10'd2;  exp17[10] = 10'd12; exp17[11] = 10'd14; exp17[12] = 10'd10;
    exp17[13] = 10'd4;  exp17[14] = 10'd11; exp17[15] = 10'd8;  exp17[16] = 10'd16;

    bus.start = 1'b0;
    bus.p     = 10'd17;
    bus.a     = 10'd0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset ready", 32'(bus.result_ready), 32'd0);
    chk("reset no_inverse", 32'(bus.no_inverse), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Basic inverse of 3 mod 17
    run_op("p17 a3", 10'd17, 10'd3, 10'd6, cyc);
    @(negedge clk);
    chk("p17 a3 held", 32'(bus.result_ready), 32'd1);
    chk("p17 a3 held result", 32'(bus.result), 32'd6);

    // a = 1 finishes in two cycles
    run_op("p17 a1", 10'd17, 10'd1, 10'd1, cyc);
    chk("p17 a1 latency", 32'(cyc), 32'd2);

    // Full sweep mod 17
    for (int i = 2; i <= 16; i++) begin
      run_op($sformatf("p17 a%0d", i), 10'd17, 10'(i), exp17[i], cyc);
    end

    // Zero operand is flagged, result cleared, two-cycle latency
    launch(10'd17, 10'd0);
    chk("a0 busy", 32'(bus.busy), 32'd1);
    chk("a0 result_cleared", 32'(bus.result), 32'd0);
    wait_done(cyc);
    chk("a0 latency", 32'(cyc), 32'd2);
    chk("a0 no_inverse", 32'(bus.no_inverse), 32'd1);
    chk("a0 ready", 32'(bus.result_ready), 32'd0);
    chk("a0 result", 32'(bus.result), 32'd0);
    chk("a0 busy_done", 32'(bus.busy), 32'd0);

    // Large prime corner values
    run_op("p1021 a2", 10'd1021, 10'd2, 10'd511, cyc);
    run_op("p1021 a1020", 10'd1021, 10'd1020, 10'd1020, cyc);

    // start while busy is ignored
    launch(10'd17, 10'd5);
    repeat (2) @(negedge clk);
    chk("ignore busy_before", 32'(bus.busy), 32'd1);
    bus.a     = 10'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ignore result", 32'(bus.result), 32'd7);
    chk("ignore ready", 32'(bus.result_ready), 32'd1);
    chk("ignore latency", 32'(cyc <= 4 * N + 2), 32'd1);

    // Back-to-back start from DONE
    run_op("b2b a7", 10'd17, 10'd7, 10'd5, cyc);

    // Reset mid-run aborts
    launch(10'd17, 10'd3);
    @(negedge clk);
    chk("abort busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort result", 32'(bus.result), 32'd0);
    chk("abort ready", 32'(bus.result_ready), 32'd0);
    chk("abort no_inverse", 32'(bus.no_inverse), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort stays idle", 32'(bus.busy), 32'd0);
    run_op("after abort a3", 10'd17, 10'd3, 10'd6, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
